// File: rtl/vip_pkg.sv
// Shared constants and types for the VIP 3x3 window path and its downstream
// operators (state encoding, default widths, sync-path latency).
package vip_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 10;

  localparam logic WAIT_FRAME = 1'b0;
  localparam logic ACTIVE     = 1'b1;

  // Input-to-window latency in clocks; downstream sync alignment keys off this.
  localparam int unsigned PIPE_LAT = 2;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/vip_sync_delay.sv
// N-stage register delay of the {vsync, href, clken} frame sync bundle,
// shared by the window generator and the Sobel stage.
module vip_sync_delay
  import vip_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT
) (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_vsync,
  input  logic i_href,
  input  logic i_clken,
  output logic o_vsync,
  output logic o_href,
  output logic o_clken
);

  sync_t w_in;
  assign w_in = {i_vsync, i_href, i_clken};

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    sync_t r_q;
    if (g == 0) begin : g_head
      always_ff @(posedge i_clock) begin
        if (!i_rst_n) r_q <= '0;
        else          r_q <= w_in;
      end
    end else begin : g_tail
      always_ff @(posedge i_clock) begin
        if (!i_rst_n) r_q <= '0;
        else          r_q <= g_stage[g-1].r_q;
      end
    end
  end

  assign o_vsync = g_stage[DEPTH-1].r_q.vsync;
  assign o_href  = g_stage[DEPTH-1].r_q.href;
  assign o_clken = g_stage[DEPTH-1].r_q.clken;

endmodule

// File: rtl/vip_matrix_3x3_gen.sv
// 3x3 window generator: registers the current row and two line-buffer taps,
// shifts them into a window, tracks row/column and applies border fill.
// Define VIP_BORDER_REPLICATE_EN to replicate edge pixels instead of zero fill.
module vip_matrix_3x3_gen
  import vip_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] row_cur,
  input  logic [DATA_W-1:0] row_prev1,
  input  logic [DATA_W-1:0] row_prev2,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33,
  output logic              matrix_valid
);

  localparam int unsigned ROW_W = 3 * DATA_W;

  logic r_state;
  logic r_vsync_d;
  logic w_vs_rise;
  logic w_in_en;

  assign w_vs_rise = per_frame_vsync & ~r_vsync_d;
  // The frame-start cycle itself must enter the pipe, so it opens the gate too.
  assign w_in_en   = (r_state == ACTIVE) | w_vs_rise;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state   <= WAIT_FRAME;
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= per_frame_vsync;
      if (w_vs_rise) r_state <= ACTIVE;
    end
  end

  logic [DATA_W-1:0] r_s1_cur;
  logic [DATA_W-1:0] r_s1_prev1;
  logic [DATA_W-1:0] r_s1_prev2;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_s1_cur   <= '0;
      r_s1_prev1 <= '0;
      r_s1_prev2 <= '0;
    end else begin
      r_s1_cur   <= row_cur;
      r_s1_prev1 <= row_prev1;
      r_s1_prev2 <= row_prev2;
    end
  end

  logic w_s1_vsync;
  logic w_s1_href;
  logic w_s1_clken;

  vip_sync_delay #(.DEPTH(1)) u_sync_s1 (
    .i_clock (clock),
    .i_rst_n (rst_n),
    .i_vsync (per_frame_vsync & w_in_en),
    .i_href  (per_frame_href  & w_in_en),
    .i_clken (per_frame_clken & w_in_en),
    .o_vsync (w_s1_vsync),
    .o_href  (w_s1_href),
    .o_clken (w_s1_clken)
  );

  vip_sync_delay #(.DEPTH(PIPE_LAT - 1)) u_sync_s2 (
    .i_clock (clock),
    .i_rst_n (rst_n),
    .i_vsync (w_s1_vsync),
    .i_href  (w_s1_href),
    .i_clken (w_s1_clken),
    .o_vsync (post_frame_vsync),
    .o_href  (post_frame_href),
    .o_clken (post_frame_clken)
  );

  // Window rows packed column 1 (oldest) at the MSB end, column 3 at the LSB end.
  logic [ROW_W-1:0] r_w1;
  logic [ROW_W-1:0] r_w2;
  logic [ROW_W-1:0] r_w3;
  logic             w_accept;

  assign w_accept = w_s1_href & w_s1_clken;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_w1 <= '0;
      r_w2 <= '0;
      r_w3 <= '0;
    end else if (w_accept) begin
      r_w1 <= {r_w1[2*DATA_W-1:0], r_s1_prev2};
      r_w2 <= {r_w2[2*DATA_W-1:0], r_s1_prev1};
      r_w3 <= {r_w3[2*DATA_W-1:0], r_s1_cur};
    end
  end

  // Edges are taken between stage 1 and the final stage, so the counters
  // describe the pixel held in p33 (valid while the final stage is stage 2).
  logic [CNT_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] r_col_cnt;
  logic             r_col_any;
  logic             w_href_fall;
  logic             w_vs_rise_s1;

  assign w_href_fall  = ~w_s1_href & post_frame_href;
  assign w_vs_rise_s1 = w_s1_vsync & ~post_frame_vsync;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      r_col_any <= 1'b0;
    end else begin
      if (w_vs_rise_s1) begin
        r_row_cnt <= '0;
      end else if (w_href_fall && (r_row_cnt != '1)) begin
        r_row_cnt <= r_row_cnt + CNT_W'(1);
      end

      if (!w_s1_href) begin
        r_col_cnt <= '0;
        r_col_any <= 1'b0;
      end else if (w_s1_clken) begin
        r_col_any <= 1'b1;
        if (!r_col_any) begin
          r_col_cnt <= '0;
        end else if (r_col_cnt != '1) begin
          r_col_cnt <= r_col_cnt + CNT_W'(1);
        end
      end
    end
  end

  logic w_row1_ok;
  logic w_row2_ok;
  logic w_col1_ok;
  logic w_col2_ok;

  assign w_row1_ok = (r_row_cnt >= CNT_W'(2));
  assign w_row2_ok = (r_row_cnt >= CNT_W'(1));
  assign w_col1_ok = (r_col_cnt >= CNT_W'(2));
  assign w_col2_ok = (r_col_cnt >= CNT_W'(1));

  assign matrix_valid = post_frame_clken & post_frame_href & w_row1_ok & w_col1_ok;

  logic [ROW_W-1:0] w_r1;
  logic [ROW_W-1:0] w_r2;
  logic [ROW_W-1:0] w_r3;

  always_comb begin
    w_r1 = r_w1;
    w_r2 = r_w2;
    w_r3 = r_w3;
`ifdef VIP_BORDER_REPLICATE_EN
    // Columns first, so a missing row copies an already column-filled row.
    if (!w_col1_ok) begin
      w_r1[ROW_W-1 -: DATA_W] = r_w1[DATA_W-1:0];
      w_r2[ROW_W-1 -: DATA_W] = r_w2[DATA_W-1:0];
      w_r3[ROW_W-1 -: DATA_W] = r_w3[DATA_W-1:0];
    end
    if (!w_col2_ok) begin
      w_r1[2*DATA_W-1 -: DATA_W] = r_w1[DATA_W-1:0];
      w_r2[2*DATA_W-1 -: DATA_W] = r_w2[DATA_W-1:0];
      w_r3[2*DATA_W-1 -: DATA_W] = r_w3[DATA_W-1:0];
    end
    if (!w_row2_ok) w_r2 = w_r3;
    if (!w_row1_ok) w_r1 = w_r2;
`else
    if (!w_col1_ok) begin
      w_r1[ROW_W-1 -: DATA_W] = '0;
      w_r2[ROW_W-1 -: DATA_W] = '0;
      w_r3[ROW_W-1 -: DATA_W] = '0;
    end
    if (!w_col2_ok) begin
      w_r1[2*DATA_W-1 -: DATA_W] = '0;
      w_r2[2*DATA_W-1 -: DATA_W] = '0;
      w_r3[2*DATA_W-1 -: DATA_W] = '0;
    end
    if (!w_row2_ok) w_r2 = '0;
    if (!w_row1_ok) w_r1 = '0;
`endif
  end

  assign matrix_p11 = w_r1[ROW_W-1 -: DATA_W];
  assign matrix_p12 = w_r1[2*DATA_W-1 -: DATA_W];
  assign matrix_p13 = w_r1[DATA_W-1:0];
  assign matrix_p21 = w_r2[ROW_W-1 -: DATA_W];
  assign matrix_p22 = w_r2[2*DATA_W-1 -: DATA_W];
  assign matrix_p23 = w_r2[DATA_W-1:0];
  assign matrix_p31 = w_r3[ROW_W-1 -: DATA_W];
  assign matrix_p32 = w_r3[2*DATA_W-1 -: DATA_W];
  assign matrix_p33 = w_r3[DATA_W-1:0];

endmodule

// File: doc/vip_matrix_3x3_gen.md
Name: vip_matrix_3x3_gen

Overview:
- Reader side of the two-row line buffer.
- Consumes the current-row pixel stream plus the two buffered row taps and assembles a registered 3x3 pixel window for downstream edge operators (Sobel/median).
- Regenerates frame sync signals delayed to match the window.
- Tracks row/column position, flags windows lying wholly inside the frame, and applies border fill.

Parameters:
- DATA_W, 8, pixel width.
- CNT_W, 10, row/column counter width; max line length 1024.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- per_frame_vsync  in  1  input frame sync, active high.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel strobe.
- row_cur  in  DATA_W  current-row pixel.
- row_prev1  in  DATA_W  pixel one row above, from the line buffer.
- row_prev2  in  DATA_W  pixel two rows above, from the line buffer.
- post_frame_vsync  out  1  vsync delayed 2 clocks.
- post_frame_href  out  1  href delayed 2 clocks.
- post_frame_clken  out  1  clken delayed 2 clocks.
- matrix_p11..p13, p21..p23, p31..p33  out  DATA_W each  window. Row 1 = oldest row; column 3 = newest pixel.
- matrix_valid  out  1  window fully inside the frame; aligned with post_frame_clken.

Behaviour:
- Clocking: one clock; rst_n is synchronous, active low.
- Reset: all outputs 0, counters 0, FSM -> WAIT_FRAME.
- FSM WAIT_FRAME:
  - All post_* outputs and matrix_valid forced 0.
  - Inputs ignored.
  - Rising edge of per_frame_vsync -> ACTIVE.
  - Any frame interrupted by reset is discarded; processing resumes at the next frame.
- FSM ACTIVE:
  - Normal pipeline.
  - Another vsync rising edge keeps ACTIVE and clears row_cnt.
- Stage 1: registers row_cur/row_prev1/row_prev2 and the three sync inputs.
- Stage 2:
  - When stage-1 clken=1 and href=1, shift each window row left: p_x1<=p_x2, p_x2<=p_x3, p_x3<=new. p1x takes row_prev2, p2x takes row_prev1, p3x takes row_cur.
  - When clken=0, the window holds.
- Total latency: 2 clocks from input to post_* and window, fixed, independent of clken duty cycle.
- col_cnt:
  - Increments on each accepted pixel (href&clken).
  - Cleared while href=0.
  - Saturates at 2^CNT_W-1, no wrap.
- row_cnt:
  - Increments on href falling edge.
  - Cleared on vsync rising edge.
  - Saturates at 2^CNT_W-1.
- matrix_valid = post_frame_clken & post_frame_href & (row_cnt>=2) & (col_cnt>=2), with counters sampled for the pixel now in p33.
- Border fill, when the window is not valid:
  - p1x when row_cnt==0 or 1, and p2x when row_cnt==0: zero.
  - Left columns with col_cnt<2: zero, for each column index below 2.
  - Fill is applied to outputs only; the shift registers hold true data.
- Simultaneous vsync rise and href fall: the row_cnt clear wins.
- href low between lines: window holds the last line's pixels; the first two accepted pixels of the next line overwrite the left columns before valid.
- clken asserted while href low: ignored, no shift, no count.

Optional Feature:
- Macro: VIP_BORDER_REPLICATE_EN.
- Defined: border positions replicate the nearest in-frame pixel instead of zero.
  - Missing rows copy the current row p3x; row 1 copies p2x if valid, else p3x.
  - Missing left columns copy column 3.
  - matrix_valid unchanged.
- Undefined: zero fill as above.

Decomposition:
- Package vip_pkg:
  - localparams for DATA_W default and CNT_W default.
  - FSM state encoding (WAIT_FRAME=1'b0, ACTIVE=1'b1).
  - Constant for the 2-clock pipeline latency, shared with downstream sync-delay logic.
- One natural sub-module: vip_sync_delay, an N-stage shift of {vsync, href, clken}. It is reused by the Sobel stage for its own alignment.

Test Plan:
- Reset then no vsync, drive href/clken with pixels 0x10.. -> all outputs stay 0, matrix_valid 0.
- vsync pulse, then 3 lines of 4 pixels with row_cur=row*16+col and row_prev1/row_prev2 = prior rows. On line 2 col 2 -> p11..p33 = 0x00,0x01,0x02 / 0x10,0x11,0x12 / 0x20,0x21,0x22, matrix_valid=1 exactly 2 clocks after that input clken.
- Same stream, line 0 col 3 -> p1x=p2x=0, matrix_valid=0. With VIP_BORDER_REPLICATE_EN -> p1x=p2x=p3x=0x01,0x02,0x03.
- clken toggling 1-0-0-1 mid-line -> window holds across gaps; post_frame_clken mirrors input pattern delayed exactly 2 clocks.
- rst_n low for 1 clock mid-line 2 -> outputs 0 next clock; no matrix_valid until after the next vsync rising edge plus two full lines.
- Line of 1100 pixels -> col_cnt saturates at 1023, no wrap; matrix_valid remains 1 through the line end.
